qos_arb4_ctrl: RTL

QOS_ARB4_CTRL -- requirements
Module: qos_arb4_ctrl

---
 rtl/qos_arb4_ctrl_pkg.sv | 18 +
 rtl/qos_arb4_ctrl_prio_enc4.sv | 24 ++
 rtl/qos_arb4_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/qos_arb4_ctrl_pkg.sv
// Shared definitions for the four-source QoS arbiter: state encoding, source count and
// default threshold values.
package qos_arb4_ctrl_pkg;

  localparam int unsigned NumSrc  = 4;
  localparam int unsigned SrcIdxW = 2;

  localparam int unsigned DefBajo = 1;
  localparam int unsigned DefAlto = 14;

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StIdle   = 2'd1,
    StActive = 2'd2,
    StPause  = 2'd3
  } state_e;

endpackage

// File: rtl/qos_arb4_ctrl_prio_enc4.sv
// Fixed-priority encoder over four requests; index 0 wins. Produces a one-hot grant and the
// binary index of the granted request (both zero when nothing requests).
module prio_enc4
  import qos_arb4_ctrl_pkg::*;
(
  input  logic [NumSrc-1:0]  req_i,
  output logic [NumSrc-1:0]  gnt_o,
  output logic [SrcIdxW-1:0] idx_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    // Walk from the lowest priority upward so the last hit is the lowest index.
    for (int i = NumSrc - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = SrcIdxW'(i);
      end
    end
  end

endmodule

// File: rtl/qos_arb4_ctrl.sv
// Four-source QoS arbiter: drains source FIFOs by fixed priority into one destination FIFO,
// throttled by destination fill level with almost-full / almost-empty hysteresis.
module qos_arb4_ctrl
  import qos_arb4_ctrl_pkg::*;
#(
  parameter int unsigned BW       = 6,
  parameter int unsigned LEN      = 16,
  parameter int unsigned DEF_BAJO = DefBajo,
  parameter int unsigned DEF_ALTO = DefAlto
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [LEN-1:0]       umbral_bajo_in,
  input  logic [LEN-1:0]       umbral_alto_in,
  input  logic [NumSrc-1:0]    src_empty,
  input  logic [NumSrc*BW-1:0] src_data,
  input  logic                 dst_full,
  input  logic                 dst_almost_full,
  input  logic                 dst_almost_empty,
  input  logic                 dst_empty,
  output logic [NumSrc-1:0]    src_rd,
  output logic                 dst_wr,
  output logic [BW-1:0]        dst_data,
  output logic [LEN-1:0]       umbral_bajo,
  output logic [LEN-1:0]       umbral_alto,
  output logic [1:0]           state,
  output logic                 idle
);

  state_e               state_q, state_d;
  logic [LEN-1:0]       bajo_q, bajo_d;
  logic [LEN-1:0]       alto_q, alto_d;
  logic                 dst_wr_q;
  logic [BW-1:0]        dst_data_q, dst_data_d;

  logic [NumSrc-1:0]    src_req;
  logic [NumSrc-1:0]    gnt;
  logic [SrcIdxW-1:0]   gnt_idx;
  logic                 rd_en;
  logic                 rd_any;
  logic [BW-1:0]        rd_word;

  assign src_req = ~src_empty;

  prio_enc4 u_prio_enc4 (
    .req_i (src_req),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Reads stop in the same cycle the destination reports almost-full, leaving headroom for
  // the one word already in the pipeline.
  assign rd_en  = (state_q == StActive) && !dst_almost_full && !dst_full;
  assign src_rd = rd_en ? gnt : '0;
  assign rd_any = |src_rd;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (gnt_idx == SrcIdxW'(i)) begin
        rd_word = src_data[i*BW +: BW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = StInit;
    end else begin
      case (state_q)
        StInit: state_d = StIdle;
        StIdle: begin
          if (!(&src_empty)) state_d = StActive;
        end
        StActive: begin
          if (dst_almost_full || dst_full) begin
            state_d = StPause;
          end else if (&src_empty) begin
            state_d = StIdle;
          end
        end
        StPause: begin
          if ((dst_almost_empty || dst_empty) && !dst_full) state_d = StActive;
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_comb begin
    bajo_d     = bajo_q;
    alto_d     = alto_q;
    dst_data_d = dst_data_q;
    if (state_q == StInit) begin
      bajo_d = umbral_bajo_in;
      alto_d = umbral_alto_in;
    end
    if (rd_any) begin
      dst_data_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StInit;
      bajo_q     <= LEN'(DEF_BAJO);
      alto_q     <= LEN'(DEF_ALTO);
      dst_wr_q   <= 1'b0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      bajo_q     <= bajo_d;
      alto_q     <= alto_d;
      dst_wr_q   <= rd_any;
      dst_data_q <= dst_data_d;
    end
  end

  assign dst_wr      = dst_wr_q;
  assign dst_data    = dst_data_q;
  assign umbral_bajo = bajo_q;
  assign umbral_alto = alto_q;
  assign state       = state_q;
  assign idle        = (state_q == StIdle) && !dst_wr_q;

endmodule
